// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the sample-memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 23;
  localparam int DEF_DATA_WIDTH = 16;

  localparam logic REQ_LOAD = 1'b0;
  localparam logic REQ_PLAY = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_access_arbiter_if.sv
// rtl/mem_access_arbiter_if.sv - requester and memory-side signal bundle for the arbiter.
interface mem_access_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  req0, req1;
  logic                  wr0, wr1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  ack0, ack1;
  logic                  rvalid0, rvalid1;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;
  logic                  mem_reset;
  logic                  mem_we, mem_oe;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_dout,
    input  ack0, ack1, rvalid0, rvalid1, rdata, busy,
    input  mem_reset, mem_we, mem_oe, mem_addr, mem_din
  );

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_dout,
    output ack0, ack1, rvalid0, rvalid1, rdata, busy,
    output mem_reset, mem_we, mem_oe, mem_addr, mem_din
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with last-grant memory.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic       o_valid,
  output logic       o_grant
);

  logic r_last;

  always_comb begin
    o_valid = |i_req;
    o_grant = i_req[1];
    if (i_req == 2'b11) o_grant = ~r_last;
  end

  // Reset to the playback side so the loader wins the first contention.
  always_ff @(posedge clk) begin
    if (!reset) r_last <= REQ_PLAY;
    else if (i_update && o_valid) r_last <= o_grant;
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - round-robin access sequencer for the shared sample memory.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input logic                 clk,
  input logic                 reset,
  mem_access_arbiter_if.slave bus
);

  state_t                r_state, w_next;
  logic                  w_gnt_valid, w_gnt, w_grant_now;
  logic                  r_sel, r_wr, r_cap_pend;
  logic [ADDR_WIDTH-1:0] r_addr, r_mem_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_mem_din, r_rdata;
  logic                  r_ack0, r_ack1, r_rvalid0, r_rvalid1;
  logic                  r_busy, r_mem_reset, r_mem_we, r_mem_oe;

  assign w_grant_now = (r_state == ST_IDLE) && w_gnt_valid;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .reset    (reset),
    .i_req    ({bus.req1, bus.req0}),
    .i_update (w_grant_now),
    .o_valid  (w_gnt_valid),
    .o_grant  (w_gnt)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_grant_now) w_next = ST_ACCESS;
      ST_ACCESS:  w_next = r_wr ? ST_IDLE : ST_CAPTURE;
      ST_CAPTURE: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Memory strobes lag the state by one cycle; read data lands one cycle after
  // CAPTURE, so r_cap_pend carries the capture into the following IDLE cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sel       <= REQ_LOAD;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_oe    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
      r_cap_pend  <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata     <= '0;
      r_mem_reset <= 1'b1;
    end else begin
      r_mem_reset <= 1'b0;
      r_ack0      <= w_grant_now && (w_gnt == REQ_LOAD);
      r_ack1      <= w_grant_now && (w_gnt == REQ_PLAY);
      if (w_grant_now) begin
        r_sel   <= w_gnt;
        r_wr    <= (w_gnt == REQ_PLAY) ? bus.wr1    : bus.wr0;
        r_addr  <= (w_gnt == REQ_PLAY) ? bus.addr1  : bus.addr0;
        r_wdata <= (w_gnt == REQ_PLAY) ? bus.wdata1 : bus.wdata0;
      end
      r_busy   <= (r_state != ST_IDLE);
      r_mem_we <= (r_state == ST_ACCESS) && r_wr;
      r_mem_oe <= ((r_state == ST_ACCESS) && !r_wr) || (r_state == ST_CAPTURE);
      if (r_state == ST_ACCESS) begin
        r_mem_addr <= r_addr;
        if (r_wr) r_mem_din <= r_wdata;
      end
      r_cap_pend <= (r_state == ST_CAPTURE);
      r_rvalid0  <= r_cap_pend && (r_sel == REQ_LOAD);
      r_rvalid1  <= r_cap_pend && (r_sel == REQ_PLAY);
      if (r_cap_pend) r_rdata <= bus.mem_dout;
    end
  end

  assign bus.ack0      = r_ack0;
  assign bus.ack1      = r_ack1;
  assign bus.rvalid0   = r_rvalid0;
  assign bus.rvalid1   = r_rvalid1;
  assign bus.rdata     = r_rdata;
  assign bus.busy      = r_busy;
  assign bus.mem_reset = r_mem_reset;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_oe    = r_mem_oe;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_din   = r_mem_din;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - directed bench with transaction-timing scoreboard for mem_access_arbiter.
module tb_mem_access_arbiter;

  localparam int NC = 1024;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  mem_access_arbiter_if #(.ADDR_WIDTH(23), .DATA_WIDTH(16)) bus ();

  mem_access_arbiter #(.ADDR_WIDTH(23), .DATA_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read sample memory seen by the arbiter.
  logic [15:0] ram [logic [22:0]];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] = bus.mem_din;
    if (bus.mem_oe) bus.mem_dout <= ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : 16'h0;
  end

  // Expected outputs per cycle, filled in at grant time from the access rules.
  bit          e_ack0 [NC];
  bit          e_ack1 [NC];
  bit          e_rv0  [NC];
  bit          e_rv1  [NC];
  bit          e_we   [NC];
  bit          e_oe   [NC];
  bit          e_busy [NC];
  bit          e_mrst [NC];
  logic [22:0] e_addr [NC];
  logic [15:0] e_din  [NC];
  logic [15:0] e_rdat [NC];
  logic [15:0] mdl_mem [logic [22:0]];
  bit          mdl_last = 1'b1;
  int          idle_at = 0;

  always @(posedge clk) begin
    logic        w, wr;
    logic [22:0] a;
    logic [15:0] d;
    cyc = cyc + 1;
    if (cyc + 4 < NC) begin
      e_mrst[cyc] = !reset;
      if (!reset) begin
        for (int j = cyc; j <= cyc + 3; j++) begin
          e_ack0[j] = 0; e_ack1[j] = 0; e_rv0[j] = 0; e_rv1[j] = 0;
          e_we[j] = 0; e_oe[j] = 0; e_busy[j] = 0;
        end
        mdl_last = 1'b1;
        idle_at  = cyc + 1;
      end else if (cyc >= idle_at && (bus.req0 || bus.req1)) begin
        w  = (bus.req0 && bus.req1) ? !mdl_last : bus.req1;
        mdl_last = w;
        wr = w ? bus.wr1   : bus.wr0;
        a  = w ? bus.addr1 : bus.addr0;
        d  = w ? bus.wdata1 : bus.wdata0;
        if (w) e_ack1[cyc] = 1; else e_ack0[cyc] = 1;
        e_busy[cyc+1] = 1;
        e_addr[cyc+1] = a;
        if (wr) begin
          e_we[cyc+1]  = 1;
          e_din[cyc+1] = d;
          mdl_mem[a]   = d;
          idle_at      = cyc + 2;
        end else begin
          e_oe[cyc+1]   = 1;
          e_oe[cyc+2]   = 1;
          e_addr[cyc+2] = a;
          e_busy[cyc+2] = 1;
          if (w) e_rv1[cyc+3] = 1; else e_rv0[cyc+3] = 1;
          e_rdat[cyc+3] = mdl_mem.exists(a) ? mdl_mem[a] : 16'h0;
          idle_at       = cyc + 3;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < NC) begin
      chk("ack0", bus.ack0, e_ack0[cyc]);
      chk("ack1", bus.ack1, e_ack1[cyc]);
      chk("rvalid0", bus.rvalid0, e_rv0[cyc]);
      chk("rvalid1", bus.rvalid1, e_rv1[cyc]);
      chk("mem_we", bus.mem_we, e_we[cyc]);
      chk("mem_oe", bus.mem_oe, e_oe[cyc]);
      chk("busy", bus.busy, e_busy[cyc]);
      chk("mem_reset", bus.mem_reset, e_mrst[cyc]);
      if (e_we[cyc] || e_oe[cyc]) chk("mem_addr", bus.mem_addr, e_addr[cyc]);
      if (e_we[cyc]) chk("mem_din", bus.mem_din, e_din[cyc]);
      if (e_rv0[cyc] || e_rv1[cyc]) chk("rdata", bus.rdata, e_rdat[cyc]);
      chk("we_oe_exclusive", bus.mem_we & bus.mem_oe, 0);
      chk("ack_exclusive", bus.ack0 & bus.ack1, 0);
      chk("ack_while_busy", (bus.ack0 | bus.ack1) & bus.busy, 0);
    end
  end

  task automatic wait_ack(input int which, output int g);
    g = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((which == 0 && bus.ack0) || (which == 1 && bus.ack1)) begin
        g = cyc;
        break;
      end
    end
    n_assert++;
    if (g < 0) begin
      n_fail++;
      $display("FAIL wait_ack%0d: got no ack expected ack within 20 cycles", which);
    end
  endtask

  int seq[$];
  int rv0_cnt, rv1_cnt;

  task automatic note_rv();
    if (bus.rvalid0) begin rv0_cnt++; chk("cont_rdata0", bus.rdata, 16'h1234); end
    if (bus.rvalid1) begin rv1_cnt++; chk("cont_rdata1", bus.rdata, 16'hA5A5); end
  endtask

  initial begin
    int g;
    int first;
    reset = 1'b0;
    bus.req0 = 1; bus.req1 = 1; bus.wr0 = 0; bus.wr1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_ack0", bus.ack0, 0);
      chk("rst_ack1", bus.ack1, 0);
      chk("rst_we", bus.mem_we, 0);
      chk("rst_oe", bus.mem_oe, 0);
      chk("rst_mem_reset", bus.mem_reset, 1);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("first_grant_ack0", bus.ack0, 1);
    chk("first_grant_ack1", bus.ack1, 0);
    chk("mem_reset_release", bus.mem_reset, 0);
    bus.req0 = 0; bus.req1 = 0;
    repeat (4) @(negedge clk);

    bus.req0 = 1; bus.wr0 = 1; bus.addr0 = 23'h000010; bus.wdata0 = 16'hA5A5;
    wait_ack(0, g);
    bus.req0 = 0;
    @(negedge clk);
    chk("wr_we", bus.mem_we, 1);
    chk("wr_addr", bus.mem_addr, 23'h000010);
    chk("wr_din", bus.mem_din, 16'hA5A5);
    @(negedge clk);
    chk("wr_busy_low", bus.busy, 0);

    bus.req0 = 1; bus.wr0 = 1; bus.addr0 = 23'h0000FF; bus.wdata0 = 16'h1234;
    wait_ack(0, g);
    bus.req0 = 0;
    bus.req1 = 1; bus.wr1 = 0; bus.addr1 = 23'h0000FF;
    wait_ack(1, g);
    bus.req1 = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("wr_rd_rvalid1", bus.rvalid1, (i == 3));
      chk("wr_rd_rvalid0", bus.rvalid0, 0);
      if (i == 3) chk("wr_rd_rdata", bus.rdata, 16'h1234);
    end

    rv0_cnt = 0; rv1_cnt = 0;
    bus.req0 = 1; bus.wr0 = 0; bus.addr0 = 23'h0000FF;
    bus.req1 = 1; bus.wr1 = 0; bus.addr1 = 23'h000010;
    for (int i = 0; i < 60 && seq.size() < 8; i++) begin
      @(negedge clk);
      if (bus.ack0) seq.push_back(0);
      if (bus.ack1) seq.push_back(1);
      note_rv();
      if (seq.size() >= 8) begin bus.req0 = 0; bus.req1 = 0; end
    end
    bus.req0 = 0; bus.req1 = 0;
    repeat (4) begin @(negedge clk); note_rv(); end
    chk("cont_grants", seq.size(), 8);
    foreach (seq[i]) chk("cont_order", seq[i], i % 2);
    chk("cont_rv0_count", rv0_cnt, 4);
    chk("cont_rv1_count", rv1_cnt, 4);

    bus.req0 = 1; bus.wr0 = 0; bus.addr0 = 23'h000010;
    wait_ack(0, g);
    bus.req0 = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_oe", bus.mem_oe, 0);
    chk("midrst_we", bus.mem_we, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_rdata", bus.rdata, 16'h0);
    chk("midrst_addr", bus.mem_addr, 23'h0);
    chk("midrst_din", bus.mem_din, 16'h0);
    chk("midrst_mem_reset", bus.mem_reset, 1);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_rv0", bus.rvalid0, 0);
      chk("midrst_no_rv1", bus.rvalid1, 0);
      chk("midrst_idle", bus.busy, 0);
    end

    bus.req0 = 1; bus.wr0 = 1; bus.addr0 = 23'h000020; bus.wdata0 = 16'h5555;
    bus.req1 = 1; bus.wr1 = 1; bus.addr1 = 23'h000021; bus.wdata1 = 16'h6666;
    first = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) begin
        first = bus.ack1 ? 1 : 0;
        break;
      end
    end
    chk("restart_prio", first, 0);
    bus.req0 = 0;
    wait_ack(1, g);
    bus.req1 = 0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
